dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 16384, storage size in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, number of WAIT cycles per access (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port chip  input  1  access request from core (MemRead|MemWrite).
REQ-006 SHALL have port MEM_Memread  input  1  read request.
REQ-007 SHALL have port MEM_Memwrite  input  1  write request.
REQ-008 SHALL have port mmwrite  input  4  active-low byte write enables; bit i=0 writes byte i; 4'b1111 = no byte written.
REQ-009 SHALL have port MEM_alu_out  input  32  byte address; word index = MEM_alu_out[log2(DEPTH)+1:2].
REQ-010 SHALL have port MEM_data_in  input  32  write data, byte lanes pre-aligned by core.
REQ-011 SHALL have port MEM_data_out  output  32  full read word (core performs byte/half extraction).
REQ-012 SHALL have port DM_stall  output  1  high while access incomplete; core holds pipeline.
REQ-013 SHALL have port err  output  1  out-of-range access flag.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-015 IDLE with chip=1: DM_stall=1 combinationally same cycle; capture address, data, mask, read/write type; load counter LATENCY-1; next WAIT.
REQ-016 IDLE with chip=0: DM_stall=0, stay IDLE, no storage access.
REQ-017 WAIT: DM_stall=1; counter decrements each cycle; at counter=0 perform captured access and go DONE.
REQ-018 Access uses captured values only; changes on inputs during WAIT SHALL have no effect.
REQ-019 Write: byte i of word updated from captured data byte i iff captured mmwrite[i]=0; other bytes unchanged.
REQ-020 Read: full word latched into read register, driven on MEM_data_out.
REQ-021 DONE: DM_stall=0 for exactly one cycle; next state IDLE unconditionally.
REQ-022 Total: request cycle plus LATENCY WAIT cycles stalled (LATENCY+1 cycles), read data valid in DONE cycle.
REQ-023 chip still high in the cycle after DONE SHALL be treated as a new request (back-to-back = LATENCY+2 cycles each).
REQ-024 MEM_Memread and MEM_Memwrite both high: write takes precedence, read register unchanged.
REQ-025 MEM_data_out SHALL hold last read value outside DONE; writes do not change it.

Reset
REQ-026 rst=1 at a clock edge: state IDLE, counter 0, read register 0, err 0; DM_stall=0 (unless chip=1 same cycle after reset, per REQ-015).
REQ-027 Reset during WAIT SHALL abandon the access; a write not yet committed SHALL NOT be performed.
REQ-028 Storage contents SHALL NOT be reset.

Configuration
REQ-029 Macro DMEM_OOB_CHECK_EN defined: word index >= DEPTH (upper address bits nonzero) suppresses write, reads return 0, err=1 during DONE cycle only.
REQ-030 Macro undefined: upper address bits ignored (address wraps modulo DEPTH words), err tied 0.

Structure
REQ-031 Package dmem_pkg SHALL hold state enum (IDLE/WAIT/DONE), default DEPTH and LATENCY constants, byte-lane count.
REQ-032 Sub-module dmem_sram_array SHALL hold storage: one read/write port, 4 active-low byte enables, synchronous write and read.

Verification
REQ-033 Write 0xDEADBEEF to 0x100, mmwrite=4'b0000, LATENCY=2 -> DM_stall high 3 cycles, low in DONE; subsequent read of 0x100 returns 0xDEADBEEF.
REQ-034 Byte write 0xAA at lane 1 (mmwrite=4'b1101, data 0x0000AA00) over 0x11223344 -> read returns 0x1122AA44.
REQ-035 Back-to-back read, read with chip held high -> two DONE cycles spaced LATENCY+2 cycles apart, each with correct data.
REQ-036 rst asserted in second WAIT cycle of write to 0x200 -> FSM IDLE, DM_stall=0, word at 0x200 unchanged.
REQ-037 With DMEM_OOB_CHECK_EN, DEPTH=16384, read 0x0001_0000 -> MEM_data_out=0, err=1 for one cycle; without macro, returns word 0, err=0.
REQ-038 Address/data changed during WAIT -> access uses values captured in request cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int DMEM_DEPTH_DEF   = 16384;
  localparam int DMEM_LATENCY_DEF = 2;
  localparam int NUM_LANES        = 4;
  localparam int LANE_W           = 8;
  localparam int CNT_W            = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  // Access captured in the request cycle; the address index lives beside it
  // in the top because its width depends on DEPTH.
  typedef struct packed {
    logic                                rd;
    logic                                wr;
    logic [NUM_LANES-1:0]                be_n;
    logic [NUM_LANES-1:0][LANE_W-1:0]    data;
  } dmem_req_t;

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port word storage, active-low byte enables, synchronous write/read.
// Each byte lane is an independent array so a masked write never touches
// neighbouring lanes. Contents are never reset.
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic                             re,
  input  logic [NUM_LANES-1:0]             be_n,
  input  logic [AW-1:0]                    addr,
  input  logic [NUM_LANES-1:0][LANE_W-1:0] wdata,
  output logic [NUM_LANES-1:0][LANE_W-1:0] rdata
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];
    logic [LANE_W-1:0] rd_q;

    // Per-lane write on enable, registered read
    always_ff @(posedge clk) begin
      if (we && !be_n[g]) mem[addr] <= wdata[g];
      if (re)             rd_q      <= mem[addr];
    end

    assign rdata[g] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: IDLE -> WAIT (LATENCY cycles) -> DONE.
// The access is captured in the request cycle and committed on the last WAIT
// edge; read data appears in DONE and is held afterwards.
// Optional: define DMEM_OOB_CHECK_EN to flag and suppress accesses whose
// word index is >= DEPTH; otherwise the address wraps modulo DEPTH words.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH_DEF,
  parameter int LATENCY = DMEM_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chip,
  input  logic        MEM_Memread,
  input  logic        MEM_Memwrite,
  input  logic [3:0]  mmwrite,
  input  logic [31:0] MEM_alu_out,
  input  logic [31:0] MEM_data_in,
  output logic [31:0] MEM_data_out,
  output logic        DM_stall,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cap;
  dmem_req_t          req_q;
  logic [AW-1:0]      idx_q;
  logic               oob_q, oob_d;
  logic [31:0]        rd_hold_q;
  logic [31:0]        sram_rdata;
  logic [31:0]        rd_word;
  logic               access, mem_we, mem_re, rd_done;
  logic               unused_addr_bits;

  // Only the word index (and, when checking, the upper bits) matter
  assign unused_addr_bits = ^{MEM_alu_out[1:0], MEM_alu_out >> (AW + 2)};

`ifdef DMEM_OOB_CHECK_EN
  assign oob_d = (MEM_alu_out >> (AW + 2)) != 32'd0;
`else
  assign oob_d = 1'b0;
`endif

  // Next state, counter load/decrement and stall
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap      = 1'b0;
    DM_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (chip) begin
          DM_stall = 1'b1;
          cap      = 1'b1;
          cnt_d    = CNT_W'(LATENCY - 1);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        DM_stall = 1'b1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Commit happens on the last WAIT edge; reset on that edge cancels it
  assign access = (state_q == WAIT) && (cnt_q == '0) && !rst;
  assign mem_we = access && req_q.wr && !oob_q;
  assign mem_re = access && req_q.rd && !req_q.wr && !oob_q;

  assign rd_done = (state_q == DONE) && req_q.rd && !req_q.wr;
  assign rd_word = oob_q ? 32'd0 : sram_rdata;

  // State, counter, captured request and held read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      idx_q     <= '0;
      oob_q     <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        req_q.rd   <= MEM_Memread;
        req_q.wr   <= MEM_Memwrite;
        req_q.be_n <= mmwrite;
        req_q.data <= MEM_data_in;
        idx_q      <= MEM_alu_out[AW+1:2];
        oob_q      <= oob_d;
      end
      if (rd_done) rd_hold_q <= rd_word;
    end
  end

  // The SRAM read register is valid in DONE; outside DONE show the held copy
  assign MEM_data_out = rd_done ? rd_word : rd_hold_q;

`ifdef DMEM_OOB_CHECK_EN
  assign err = (state_q == DONE) && oob_q;
`else
  assign err = 1'b0;
`endif

  dmem_sram_array #(.DEPTH(DEPTH), .AW(AW)) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .be_n  (req_q.be_n),
    .addr  (idx_q),
    .wdata (req_q.data),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus a randomized
// phase, checked against an associative-array memory model.
module tb_dmem_responder;

  localparam int DEPTH = 16384;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst, chip, MEM_Memread, MEM_Memwrite;
  logic [3:0]  mmwrite;
  logic [31:0] MEM_alu_out, MEM_data_in, MEM_data_out;
  logic        DM_stall, err;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .chip         (chip),
    .MEM_Memread  (MEM_Memread),
    .MEM_Memwrite (MEM_Memwrite),
    .mmwrite      (mmwrite),
    .MEM_alu_out  (MEM_alu_out),
    .MEM_data_in  (MEM_data_in),
    .MEM_data_out (MEM_data_out),
    .DM_stall     (DM_stall),
    .err          (err)
  );

  int compared = 0, mismatched = 0;
  logic [31:0] mem_m [int];
  logic [31:0] last_rd;

  function automatic bit is_oob(input logic [31:0] a);
`ifdef DMEM_OOB_CHECK_EN
    return (a >> 2) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    chip = 0; MEM_Memread = 0; MEM_Memwrite = 0; mmwrite = 4'hF;
  endtask

  // One complete access; scr scrambles the inputs while the access is pending
  task automatic do_acc(input bit rd, input bit wr, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] d, input bit scr);
    int n;
    bit oob, seen;
    logic [31:0] exp_rd, w;
    oob = is_oob(a);
    exp_rd = last_rd;
    if (rd && !wr) exp_rd = oob ? 32'd0 : mem_m[widx(a)];
    @(posedge clk); #1;
    chip = 1; MEM_Memread = rd; MEM_Memwrite = wr; mmwrite = m;
    MEM_alu_out = a; MEM_data_in = d;
    @(negedge clk);
    chk("req_stall", 32'(DM_stall), 32'd1);
    chk("req_err", 32'(err), 32'd0);
    n = 1; seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      chip = 0;
      if (scr) begin
        MEM_alu_out = $urandom; MEM_data_in = $urandom;
        mmwrite = 4'($urandom); MEM_Memread = 1'($urandom); MEM_Memwrite = 1'($urandom);
      end
      @(negedge clk);
      if (!DM_stall) begin seen = 1; break; end
      n++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("stall_cycles", 32'(n), 32'(LAT + 1));
    chk("done_data", MEM_data_out, exp_rd);
    chk("done_err", 32'(err), 32'(oob));
    if (wr && !oob) begin
      w = mem_m.exists(widx(a)) ? mem_m[widx(a)] : 32'd0;
      for (int b = 0; b < 4; b++) if (!m[b]) w[8*b +: 8] = d[8*b +: 8];
      mem_m[widx(a)] = w;
    end
    if (rd && !wr) last_rd = exp_rd;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("idle_stall", 32'(DM_stall), 32'd0);
    chk("hold_data", MEM_data_out, last_rd);
    chk("idle_err", 32'(err), 32'd0);
  endtask

  initial begin
    int t1, t2;
    logic [31:0] exp_a, exp_b;
    rst = 1; idle_inputs(); MEM_alu_out = 0; MEM_data_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(DM_stall), 32'd0);
    chk("rst_data", MEM_data_out, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1 rst = 0;
    last_rd = 0;

    // Full-word write then read back
    do_acc(0, 1, 4'b0000, 32'h100, 32'hDEADBEEF, 0);
    do_acc(1, 0, 4'b1111, 32'h100, 32'h0, 0);
    chk("deadbeef", last_rd, 32'hDEADBEEF);

    // Byte lane 1 write over an existing word
    do_acc(0, 1, 4'b0000, 32'h104, 32'h11223344, 0);
    do_acc(0, 1, 4'b1101, 32'h104, 32'h0000AA00, 0);
    do_acc(1, 0, 4'b1111, 32'h104, 32'h0, 0);
    chk("byte_merge", last_rd, 32'h1122AA44);

    // Inputs scrambled while the access is pending
    do_acc(0, 1, 4'b0000, 32'h108, 32'hCAFEF00D, 1);
    do_acc(1, 0, 4'b1111, 32'h108, 32'h0, 1);

    // Read and write together: write wins, read register unchanged
    do_acc(1, 1, 4'b0000, 32'h10C, 32'h0BADF00D, 0);
    do_acc(1, 0, 4'b1111, 32'h10C, 32'h0, 0);

    // Back-to-back reads with chip held high
    do_acc(0, 1, 4'b0000, 32'h110, 32'h01020304, 0);
    do_acc(0, 1, 4'b0000, 32'h114, 32'hA0B0C0D0, 0);
    exp_a = mem_m[widx(32'h110)]; exp_b = mem_m[widx(32'h114)];
    t1 = -1; t2 = -1;
    @(posedge clk); #1;
    chip = 1; MEM_Memread = 1; MEM_Memwrite = 0; mmwrite = 4'hF; MEM_alu_out = 32'h110;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!DM_stall) begin
        if (t1 < 0) begin t1 = k; chk("b2b_data1", MEM_data_out, exp_a); end
        else begin t2 = k; chk("b2b_data2", MEM_data_out, exp_b); break; end
      end
      @(posedge clk); #1;
      if (t1 >= 0 && k == t1) MEM_alu_out = 32'h114;
    end
    chk("b2b_first", 32'(t1), 32'(LAT + 1));
    chk("b2b_gap", 32'(t2 - t1), 32'(LAT + 2));
    last_rd = exp_b;
    @(posedge clk); #1 idle_inputs();

    // Reset in the last WAIT cycle of a write abandons it
    do_acc(0, 1, 4'b0000, 32'h200, 32'h5A5A5A5A, 0);
    @(posedge clk); #1;
    chip = 1; MEM_Memwrite = 1; mmwrite = 4'b0000; MEM_alu_out = 32'h200; MEM_data_in = 32'hFFFF0000;
    @(posedge clk); #1 idle_inputs();
    repeat (LAT - 1) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_stall", 32'(DM_stall), 32'd0);
    chk("abort_data", MEM_data_out, 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    last_rd = 0;
    do_acc(1, 0, 4'b1111, 32'h200, 32'h0, 0);
    chk("abort_kept", last_rd, 32'h5A5A5A5A);

    // Beyond DEPTH: flagged and zeroed when checking, else wraps
    do_acc(0, 1, 4'b0000, 32'h0, 32'h13579BDF, 0);
    do_acc(0, 1, 4'b0000, 32'h4, 32'h2468ACE0, 0);
    do_acc(1, 0, 4'b1111, 32'h0001_0000, 32'h0, 0);
    do_acc(0, 1, 4'b0000, 32'h0001_0004, 32'h99999999, 0);
    do_acc(1, 0, 4'b1111, 32'h4, 32'h0, 0);

    // Randomized traffic over a small window of words
    for (int i = 0; i < 8; i++) do_acc(0, 1, 4'b0000, 32'h400 + 4 * i, $urandom, 0);
    for (int i = 0; i < 30; i++)
      do_acc(1'($urandom), 1'($urandom), 4'($urandom), 32'h400 + 4 * $urandom_range(0, 7),
             $urandom, 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
